// File: rtl/avl_mem_arbiter.sv
// Two-to-one Avalon-MM burst arbiter: I-cache refill (s0) and D-cache (s1)
// share one memory master; whole bursts granted round-robin.
module avl_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic [ADDR_W-1:0]     s0_address,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [DATA_W-1:0]     s0_writedata,
  input  logic [DATA_W/8-1:0]   s0_byteenable,
  input  logic [BURST_W-1:0]    s0_burstcount,
  output logic [DATA_W-1:0]     s0_readdata,
  output logic                  s0_readdatavalid,
  output logic                  s0_waitrequest,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [BURST_W-1:0]    s1_burstcount,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic [BURST_W-1:0]    m_burstcount,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid,
  input  logic                  m_waitrequest
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RD_DATA,
    WR_DATA
  } state_e;

  state_e               state_q;
  logic                 gnt_q;
  logic                 last_q;
  logic [BURST_W-1:0]   cnt_q;

  logic                 req0;
  logic                 req1;
  logic                 arb_g;
  logic [ADDR_W-1:0]    g_addr;
  logic                 g_read;
  logic                 g_write;
  logic [DATA_W-1:0]    g_wdata;
  logic [DATA_W/8-1:0]  g_be;
  logic [BURST_W-1:0]   g_bc;

  assign req0  = s0_read | s0_write;
  assign req1  = s1_read | s1_write;
  // On a tie the port that did not win last time takes the bus
  assign arb_g = (req0 & req1) ? ~last_q : req1;

  assign g_addr  = gnt_q ? s1_address    : s0_address;
  assign g_read  = gnt_q ? s1_read       : s0_read;
  assign g_write = gnt_q ? s1_write      : s0_write;
  assign g_wdata = gnt_q ? s1_writedata  : s0_writedata;
  assign g_be    = gnt_q ? s1_byteenable : s0_byteenable;
  assign g_bc    = gnt_q ? s1_burstcount : s0_burstcount;

  assign s0_readdata = m_readdata;
  assign s1_readdata = m_readdata;

  always_comb begin
    m_address        = '0;
    m_read           = 1'b0;
    m_write          = 1'b0;
    m_writedata      = '0;
    m_byteenable     = '0;
    m_burstcount     = '0;
    s0_waitrequest   = 1'b1;
    s1_waitrequest   = 1'b1;
    s0_readdatavalid = 1'b0;
    s1_readdatavalid = 1'b0;
    unique case (state_q)
      CMD: begin
        m_address    = g_addr;
        m_read       = g_read;
        m_write      = g_write;
        m_writedata  = g_wdata;
        m_byteenable = g_be;
        m_burstcount = g_bc;
        s0_waitrequest = gnt_q | m_waitrequest;
        s1_waitrequest = ~gnt_q | m_waitrequest;
      end
      WR_DATA: begin
        m_write      = g_write;
        m_writedata  = g_wdata;
        m_byteenable = g_be;
        s0_waitrequest = gnt_q | m_waitrequest;
        s1_waitrequest = ~gnt_q | m_waitrequest;
      end
      RD_DATA: begin
        s0_readdatavalid = ~gnt_q & m_readdatavalid;
        s1_readdatavalid = gnt_q & m_readdatavalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            gnt_q   <= arb_g;
            last_q  <= arb_g;
            state_q <= CMD;
          end
        end
        CMD: begin
          if (!g_read && !g_write) begin
            state_q <= IDLE;
          end else if (!m_waitrequest) begin
            if (g_read) begin
              cnt_q   <= (g_bc == '0) ? BURST_W'(1) : g_bc;
              state_q <= RD_DATA;
            end else if (g_bc <= BURST_W'(1)) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= g_bc - BURST_W'(1);
              state_q <= WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (m_readdatavalid) begin
            cnt_q <= cnt_q - BURST_W'(1);
            if (cnt_q <= BURST_W'(1)) state_q <= IDLE;
          end
        end
        WR_DATA: begin
          if (g_write && !m_waitrequest) begin
            cnt_q <= cnt_q - BURST_W'(1);
            if (cnt_q <= BURST_W'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avl_mem_arbiter.sv
// Scoreboard bench for avl_mem_arbiter: directed bursts, memory model,
// monitor pops expected commands/read beats as the DUT presents them.
module tb_avl_mem_arbiter;

  logic        clk = 1'b0;
  logic        rest = 1'b0;
  logic        rd_r [2];
  logic        wr_r [2];
  logic [31:0] ad_r [2];
  logic [31:0] wd_r [2];
  logic [3:0]  be_r [2];
  logic [4:0]  bc_r [2];
  logic        mw = 1'b0;
  logic        mrdv = 1'b0;
  logic [31:0] mrd = '0;

  logic [31:0] s0_readdata, s1_readdata, m_address, m_writedata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic        s0_waitrequest, s1_waitrequest;
  logic        m_read, m_write;
  logic [3:0]  m_byteenable;
  logic [4:0]  m_burstcount;

  avl_mem_arbiter dut (
    .clk(clk), .rest(rest),
    .s0_address(ad_r[0]), .s0_read(rd_r[0]), .s0_write(wr_r[0]),
    .s0_writedata(wd_r[0]), .s0_byteenable(be_r[0]),
    .s0_burstcount(bc_r[0]), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid), .s0_waitrequest(s0_waitrequest),
    .s1_address(ad_r[1]), .s1_read(rd_r[1]), .s1_write(wr_r[1]),
    .s1_writedata(wd_r[1]), .s1_byteenable(be_r[1]),
    .s1_burstcount(bc_r[1]), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_burstcount(m_burstcount), .m_readdata(mrd),
    .m_readdatavalid(mrdv), .m_waitrequest(mw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        first;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  bc;
  } cmd_t;

  typedef struct {
    logic [31:0] a;
    int          n;
  } rsp_t;

  cmd_t        exp_cmd [$];
  logic [31:0] exp_rd0 [$];
  logic [31:0] exp_rd1 [$];
  rsp_t        rsp_q   [$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          seen0  = 0;
  int          seen1  = 0;
  int          wr_seen = 0;
  int          beat   = 0;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", n, got, exp);
  endtask

  task automatic fail_evt(input string n);
    n_chk++;
    $display("FAIL %s got=event exp=none", n);
  endtask

  function automatic logic wreq(input int p);
    return (p == 1) ? s1_waitrequest : s0_waitrequest;
  endfunction

  function automatic int seen(input int p);
    return (p == 1) ? seen1 : seen0;
  endfunction

  task automatic push_cmd(input logic rd, input logic wr, input logic first,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [4:0] bc);
    cmd_t e;
    e.rd = rd; e.wr = wr; e.first = first;
    e.addr = a; e.wd = wd; e.be = be; e.bc = bc;
    exp_cmd.push_back(e);
  endtask

  // monitor + memory-side command capture
  always @(negedge clk) begin
    if (rest && (m_read || m_write) && !mw) begin
      if (m_read) rsp_q.push_back('{m_address,
                                    (m_burstcount == 0) ? 1 : int'(m_burstcount)});
      if (m_write) wr_seen++;
      if (exp_cmd.size() == 0) fail_evt("cmd_unexpected");
      else begin
        cmd_t e;
        e = exp_cmd.pop_front();
        chk("cmd_read", m_read, e.rd);
        chk("cmd_write", m_write, e.wr);
        if (e.first) begin
          chk("cmd_addr", m_address, e.addr);
          chk("cmd_bc", m_burstcount, e.bc);
        end
        if (e.wr) begin
          chk("cmd_wdata", m_writedata, e.wd);
          chk("cmd_be", m_byteenable, e.be);
        end
      end
    end
    if (s0_readdatavalid) begin
      if (exp_rd0.size() == 0) fail_evt("rd0_unexpected");
      else chk("rd0_data", s0_readdata, exp_rd0.pop_front());
      seen0++;
    end
    if (s1_readdatavalid) begin
      if (exp_rd1.size() == 0) fail_evt("rd1_unexpected");
      else chk("rd1_data", s1_readdata, exp_rd1.pop_front());
      seen1++;
    end
  end

  // memory read responder, zero-latency after acceptance
  always @(posedge clk) begin
    #1;
    if (rsp_q.size() > 0) begin
      mrdv = 1'b1;
      mrd  = {rsp_q[0].a[23:0], 8'(8'hA0 + beat)};
      beat++;
      if (beat >= rsp_q[0].n) begin
        void'(rsp_q.pop_front());
        beat = 0;
      end
    end else begin
      mrdv = 1'b0;
    end
  end

  task automatic acc_wait(input int p);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (wreq(p) && t < 500);
    if (wreq(p)) fail_evt("accept_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic master_rd(input int p, input logic [31:0] a,
                           input logic [4:0] bc);
    rd_r[p] = 1'b1; ad_r[p] = a; bc_r[p] = bc; be_r[p] = 4'hF;
    acc_wait(p);
    rd_r[p] = 1'b0;
  endtask

  task automatic master_wr(input int p, input logic [31:0] a,
                           input logic [4:0] bc, input int n,
                           input logic [31:0] base);
    wr_r[p] = 1'b1; ad_r[p] = a; bc_r[p] = bc;
    for (int i = 0; i < n; i++) begin
      wd_r[p] = base + 32'(i);
      be_r[p] = 4'(1 << i);
      acc_wait(p);
    end
    wr_r[p] = 1'b0;
  endtask

  task automatic wait_seen(input int p, input int n);
    int t = 0;
    while (seen(p) < n && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (seen(p) < n) fail_evt("beat_timeout");
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_cmd.size() > 0 || exp_rd0.size() > 0 ||
            exp_rd1.size() > 0 || rsp_q.size() > 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (t >= 300) fail_evt("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_m_read"}, m_read, 0);
    chk({n, "_m_write"}, m_write, 0);
    chk({n, "_m_addr"}, m_address, 0);
    chk({n, "_m_wdata"}, m_writedata, 0);
    chk({n, "_m_be"}, m_byteenable, 0);
    chk({n, "_m_bc"}, m_burstcount, 0);
    chk({n, "_s0_wait"}, s0_waitrequest, 1);
    chk({n, "_s1_wait"}, s1_waitrequest, 1);
    chk({n, "_s0_rdv"}, s0_readdatavalid, 0);
    chk({n, "_s1_rdv"}, s1_readdatavalid, 0);
  endtask

  task automatic pulse_reset(input string n);
    @(negedge clk);
    rest = 1'b0;
    #1 chk_reset(n);
    @(negedge clk);
    rest = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    for (int p = 0; p < 2; p++) begin
      rd_r[p] = 0; wr_r[p] = 0; ad_r[p] = 0;
      wd_r[p] = 0; be_r[p] = 0; bc_r[p] = 0;
    end
    repeat (3) @(posedge clk);
    #1 chk_reset("rst0");
    @(negedge clk);
    rest = 1'b1;
    @(posedge clk);
    #1;

    // single s0 read burst, then s1 granted the cycle after IDLE
    push_cmd(1, 0, 1, 32'h1000, 0, 0, 5'd4);
    for (int i = 0; i < 4; i++) exp_rd0.push_back(32'h001000A0 + 32'(i));
    master_rd(0, 32'h1000, 5'd4);
    wait_seen(0, 4);
    #1;
    push_cmd(1, 0, 1, 32'h1100, 0, 0, 5'd1);
    exp_rd1.push_back(32'h001100A0);
    fork
      master_rd(1, 32'h1100, 5'd1);
      begin
        @(posedge clk);
        #2;
        chk("t1_idle_s1_wait", s1_waitrequest, 0);
        chk("t1_idle_m_addr", m_address, 32'h1100);
      end
    join
    drain();

    // simultaneous requests after reset: s0 first, one idle bus cycle
    pulse_reset("rst1");
    push_cmd(1, 0, 1, 32'h1000, 0, 0, 5'd2);
    push_cmd(1, 0, 1, 32'h2000, 0, 0, 5'd2);
    exp_rd0.push_back(32'h001000A0); exp_rd0.push_back(32'h001000A1);
    exp_rd1.push_back(32'h002000A0); exp_rd1.push_back(32'h002000A1);
    tgt = seen0 + 2;
    fork
      master_rd(0, 32'h1000, 5'd2);
      master_rd(1, 32'h2000, 5'd2);
      begin
        wait_seen(0, tgt);
        #1;
        chk("t2_gap_m_read", m_read, 0);
        chk("t2_gap_s1_wait", s1_waitrequest, 1);
        @(posedge clk);
        #1;
        chk("t2_cmd_m_read", m_read, 1);
        chk("t2_cmd_m_addr", m_address, 32'h2000);
        chk("t2_cmd_s1_wait", s1_waitrequest, 0);
      end
    join
    drain();

    // s1 write burst with a 2-cycle stall on beat 2; s0 read waits
    push_cmd(0, 1, 1, 32'h5000, 32'hD0, 4'h1, 5'd3);
    push_cmd(0, 1, 0, 0, 32'hD1, 4'h2, 0);
    push_cmd(0, 1, 0, 0, 32'hD2, 4'h4, 0);
    push_cmd(1, 0, 1, 32'h6000, 0, 0, 5'd1);
    exp_rd0.push_back(32'h006000A0);
    tgt = wr_seen + 1;
    fork
      master_wr(1, 32'h5000, 5'd3, 3, 32'hD0);
      begin
        @(posedge clk);
        #1;
        master_rd(0, 32'h6000, 5'd1);
      end
      begin
        int t = 0;
        while (wr_seen < tgt && t < 100) begin
          @(posedge clk);
          t++;
        end
        #1 mw = 1'b1;
        #1;
        chk("t3_stall1_s1_wait", s1_waitrequest, 1);
        chk("t3_stall1_s0_wait", s0_waitrequest, 1);
        @(posedge clk);
        #2;
        chk("t3_stall2_s1_wait", s1_waitrequest, 1);
        @(posedge clk);
        #1 mw = 1'b0;
        #1;
        chk("t3_go_s1_wait", s1_waitrequest, 0);
        chk("t3_go_s0_wait", s0_waitrequest, 1);
      end
    join
    drain();

    // round-robin: s0 three bursts, s1 two, interleaved
    push_cmd(1, 0, 1, 32'h7000, 0, 0, 5'd2);
    push_cmd(1, 0, 1, 32'h8000, 0, 0, 5'd1);
    push_cmd(1, 0, 1, 32'h7100, 0, 0, 5'd2);
    push_cmd(1, 0, 1, 32'h8100, 0, 0, 5'd1);
    push_cmd(1, 0, 1, 32'h7200, 0, 0, 5'd2);
    exp_rd0.push_back(32'h007000A0); exp_rd0.push_back(32'h007000A1);
    exp_rd0.push_back(32'h007100A0); exp_rd0.push_back(32'h007100A1);
    exp_rd0.push_back(32'h007200A0); exp_rd0.push_back(32'h007200A1);
    exp_rd1.push_back(32'h008000A0); exp_rd1.push_back(32'h008100A0);
    fork
      begin
        master_rd(0, 32'h7000, 5'd2);
        master_rd(0, 32'h7100, 5'd2);
        master_rd(0, 32'h7200, 5'd2);
      end
      begin
        @(posedge clk);
        #1;
        master_rd(1, 32'h8000, 5'd1);
        master_rd(1, 32'h8100, 5'd1);
      end
    join
    drain();

    // burstcount 0 behaves as a single beat
    push_cmd(1, 0, 1, 32'h9000, 0, 0, 5'd0);
    push_cmd(1, 0, 1, 32'h9100, 0, 0, 5'd1);
    exp_rd1.push_back(32'h009000A0);
    exp_rd0.push_back(32'h009100A0);
    master_rd(1, 32'h9000, 5'd0);
    master_rd(0, 32'h9100, 5'd1);
    drain();

    // reset in the middle of an 8-beat read
    push_cmd(1, 0, 1, 32'hA000, 0, 0, 5'd8);
    exp_rd0.push_back(32'h00A000A0); exp_rd0.push_back(32'h00A000A1);
    tgt = seen0 + 2;
    master_rd(0, 32'hA000, 5'd8);
    wait_seen(0, tgt);
    #2 rest = 1'b0;
    #1 chk_reset("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rest = 1'b1;
    drain();
    push_cmd(1, 0, 1, 32'hB000, 0, 0, 5'd2);
    exp_rd1.push_back(32'h00B000A0); exp_rd1.push_back(32'h00B000A1);
    master_rd(1, 32'hB000, 5'd2);
    drain();

    chk("left_cmd", exp_cmd.size(), 0);
    chk("left_rd0", exp_rd0.size(), 0);
    chk("left_rd1", exp_rd1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/avl_mem_arbiter.md
Name: avl_mem_arbiter

Overview:
- Two-to-one Avalon-MM burst arbiter.
- Shares one external memory bus master between the instruction-cache refill port (s0) and the data-cache refill/writeback port (s1).
- Sits between the two cache instances' memory-side masters and the bus interface unit's memory path.
- Grants whole bursts, round-robin, and holds the grant until the last beat completes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
BURST_W, 5, burstcount width (max burst 16 beats = one 64-byte line)

Ports:
clk  input  1  clock
rest  input  1  reset, asynchronous, active-low
s0_address / s1_address  input  ADDR_W  requester address
s0_read / s1_read  input  1  read request
s0_write / s1_write  input  1  write request
s0_writedata / s1_writedata  input  DATA_W  write data
s0_byteenable / s1_byteenable  input  DATA_W/8  byte enables
s0_burstcount / s1_burstcount  input  BURST_W  burst length in beats
s0_readdata / s1_readdata  output  DATA_W  read data
s0_readdatavalid / s1_readdatavalid  output  1  read beat valid
s0_waitrequest / s1_waitrequest  output  1  stall
m_address  output  ADDR_W  to memory
m_read / m_write  output  1  command
m_writedata  output  DATA_W  write data
m_byteenable  output  DATA_W/8  byte enables
m_burstcount  output  BURST_W  burst length
m_readdata  input  DATA_W  read data
m_readdatavalid  input  1  read beat valid
m_waitrequest  input  1  memory stall

Behaviour:
- Reset (rest low, async):
  - state=IDLE, last_grant=1 (so s0 wins the first tie), beat counter=0.
  - m_read=m_write=0, m_address/m_writedata/m_byteenable/m_burstcount=0.
  - s0/s1_waitrequest=1, s0/s1_readdatavalid=0.
- States: IDLE, CMD, RD_DATA, WR_DATA.
- IDLE:
  - Request = read|write of a port.
  - One port requesting: grant it. Both requesting: grant the port != last_grant.
  - Register grant, update last_grant, go to CMD.
  - Arbitration latency 1 cycle. Both waitrequests stay 1 in IDLE.
- CMD:
  - Granted port's address/read/write/writedata/byteenable/burstcount are forwarded combinationally to m_*.
  - granted s_waitrequest = m_waitrequest; the other port's waitrequest = 1.
  - Read accepted (m_read & !m_waitrequest): load counter = burstcount (0 treated as 1), go to RD_DATA.
  - Write accepted: counter = burstcount-1 (0 or 1 → burst complete), go to IDLE if complete, else WR_DATA.
  - Granted port drops both read and write before acceptance: return to IDLE, nothing issued.
- RD_DATA:
  - m_read=m_write=0.
  - m_readdata is broadcast to both s_readdata; only the granted port's readdatavalid follows m_readdatavalid.
  - Decrement counter per valid beat; on the last beat go to IDLE.
  - Both waitrequests = 1.
- WR_DATA:
  - Forward granted write/writedata/byteenable; waitrequest as in CMD.
  - Decrement counter per accepted beat; accepted beat with counter==1 → IDLE.
  - Granted write low: insert idle beats, no decrement.
- m_readdatavalid outside RD_DATA is ignored and never forwarded.
- Grant is never preempted mid-burst, whatever the other port does.
- Next arbitration happens one cycle after the last beat, so back-to-back bursts carry 1 idle bus cycle.
- Reset mid-burst:
  - Immediate return to IDLE with outputs at reset values.
  - In-flight memory beats after reset are dropped.
- Counter is BURST_W wide; no wrap, because burstcount ≤ 2^BURST_W-1.

Test Plan:
- s0 read at 0x1000, burstcount=4, m_waitrequest=0, memory returns 0xA0..0xA3 → s0_readdatavalid high for 4 cycles carrying those values; s1_readdatavalid stays 0; FSM back in IDLE after beat 4.
- s0 and s1 read in the same cycle after reset, burst 2 each → s0 served first, s1 granted next; m_address sequence 0x1000 then 0x2000; 1 idle cycle between bursts.
- s1 write, burstcount=3, m_waitrequest high on beat 2 for 2 cycles → s1_waitrequest mirrors that; exactly 3 accepted beats on m_; s0 read pending throughout stays stalled (s0_waitrequest=1) until the write completes.
- s0 issues 3 consecutive read bursts while s1 holds a request → order s0, s1, s0, s1 … (round-robin); s1 never waits more than one burst.
- rest pulsed low during RD_DATA after 2 of 8 beats → outputs at reset values asynchronously; the remaining m_readdatavalid beats produce no s_readdatavalid; a new s1 request after release is granted normally.
- burstcount=0 read → treated as 1 beat; returns to IDLE after a single readdatavalid.
